// File: rtl/bitscan_pkg.sv
// ============================================================================
// bitscan_pkg : shared types and helpers for the bit-scan encoder family
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package bitscan_pkg;

  localparam int c_max_word_width = 256;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    ZERO = 2'd2
  } bitscan_state_t;

  // OR-reduction encoder; callers zero-extend their word and cast the result.
  function automatic int onehot_to_index(input logic [c_max_word_width-1:0] onehot);
    int idx;
    idx = 0;
    for (int i = 0; i < c_max_word_width; i++) begin
      if (onehot[i]) idx = idx | i;
    end
    return idx;
  endfunction

endpackage

`default_nettype wire

// File: rtl/bitscan_pick.sv
// ============================================================================
// bitscan_pick : selects the lowest or highest set bit of a word
// Revision     : 1.0 - initial release
// ============================================================================
`default_nettype none

module bitscan_pick
  import bitscan_pkg::*;
#(
  parameter  int WORD_WIDTH  = 8,
  localparam int INDEX_WIDTH = $clog2(WORD_WIDTH)
) (
  input  logic [WORD_WIDTH-1:0]  pending,
  input  logic                   dir,
  output logic [WORD_WIDTH-1:0]  picked,
  output logic [INDEX_WIDTH-1:0] index,
  output logic                   single
);

  localparam logic [WORD_WIDTH-1:0] c_one = {{(WORD_WIDTH-1){1'b0}}, 1'b1};

  logic [WORD_WIDTH-1:0]       w_junior;
  logic [WORD_WIDTH-1:0]       w_rev;
  logic [WORD_WIDTH-1:0]       w_rev_pick;
  logic [WORD_WIDTH-1:0]       w_senior;
  logic [c_max_word_width-1:0] w_wide;

  // Senior pick is the junior pick applied to the bit-reversed word.
  genvar g;
  generate
    for (g = 0; g < WORD_WIDTH; g++) begin : g_mirror
      assign w_rev[g]    = pending[WORD_WIDTH-1-g];
      assign w_senior[g] = w_rev_pick[WORD_WIDTH-1-g];
    end
  endgenerate

  assign w_junior   = pending & (~pending + c_one);
  assign w_rev_pick = w_rev & (~w_rev + c_one);

  assign picked = dir ? w_senior : w_junior;
  assign w_wide = {{(c_max_word_width-WORD_WIDTH){1'b0}}, picked};
  assign index  = INDEX_WIDTH'(onehot_to_index(w_wide));
  assign single = (pending != '0) && ((pending & (pending - c_one)) == '0);

endmodule

`default_nettype wire

// File: rtl/bitscan_encoder.sv
// ============================================================================
// bitscan_encoder : streams the index of every set bit of an accepted word
// Revision        : 1.0 - initial release
// ============================================================================
`default_nettype none

module bitscan_encoder
  import bitscan_pkg::*;
#(
  parameter  int WORD_WIDTH  = 8,
  localparam int INDEX_WIDTH = $clog2(WORD_WIDTH)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [WORD_WIDTH-1:0]  in_word,
  input  logic                   in_dir,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [INDEX_WIDTH-1:0] out_index,
  output logic                   out_last,
  output logic                   out_empty
);

  bitscan_state_t          r_state;
  logic [WORD_WIDTH-1:0]   r_pending;
  logic                    r_dir;

  logic [WORD_WIDTH-1:0]   w_picked;
  logic [INDEX_WIDTH-1:0]  w_pick_index;
  logic                    w_single;
  logic                    w_beat;
  logic                    w_accept;

  bitscan_pick #(
    .WORD_WIDTH (WORD_WIDTH)
  ) u_pick (
    .pending (r_pending),
    .dir     (r_dir),
    .picked  (w_picked),
    .index   (w_pick_index),
    .single  (w_single)
  );

  // Outputs are decoded from registers only; reset forces every one low.
  always_comb begin
    out_valid = 1'b0;
    out_index = '0;
    out_last  = 1'b0;
    out_empty = 1'b0;
    if (!reset) begin
      case (r_state)
        SCAN: begin
          out_valid = 1'b1;
          out_index = w_pick_index;
          out_last  = w_single;
        end
        ZERO: begin
          out_valid = 1'b1;
          out_last  = 1'b1;
          out_empty = 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign w_beat   = out_valid && out_ready;
  assign in_ready = !reset && ((r_state == IDLE) || (w_beat && out_last));
  assign w_accept = in_valid && in_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= IDLE;
      r_pending <= '0;
      r_dir     <= 1'b0;
    end else if (w_accept) begin
      r_dir <= in_dir;
      if (in_word != '0) begin
        r_pending <= in_word;
        r_state   <= SCAN;
      end else begin
        r_pending <= '0;
        r_state   <= ZERO;
      end
    end else if (w_beat) begin
      if (out_last) begin
        r_state   <= IDLE;
        r_pending <= '0;
      end else begin
        r_pending <= r_pending & ~w_picked;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_bitscan_encoder.sv
// ============================================================================
// tb_bitscan_encoder : directed scoreboard bench for bitscan_encoder
// Revision           : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_bitscan_encoder;

  localparam int WORD_WIDTH  = 8;
  localparam int INDEX_WIDTH = $clog2(WORD_WIDTH);

  logic                   clk = 1'b0;
  logic                   reset;
  logic                   in_valid;
  logic                   in_ready;
  logic [WORD_WIDTH-1:0]  in_word;
  logic                   in_dir;
  logic                   out_valid;
  logic                   out_ready;
  logic [INDEX_WIDTH-1:0] out_index;
  logic                   out_last;
  logic                   out_empty;

  typedef struct {
    int idx;
    int last;
    int empty;
  } exp_t;

  exp_t q_exp[$];
  int   checks = 0;
  int   errors = 0;

  bitscan_encoder #(
    .WORD_WIDTH (WORD_WIDTH)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_word   (in_word),
    .in_dir    (in_dir),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_index (out_index),
    .out_last  (out_last),
    .out_empty (out_empty)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic push(input int idx, input int last, input int empty);
    exp_t e;
    e.idx   = idx;
    e.last  = last;
    e.empty = empty;
    q_exp.push_back(e);
  endtask

  // Presents a word and returns 1 time unit after the accepting edge.
  task automatic send(input logic [WORD_WIDTH-1:0] word, input logic dir);
    bit ok;
    ok       = 1'b0;
    in_valid = 1'b1;
    in_word  = word;
    in_dir   = dir;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (in_ready) begin
        ok = 1'b1;
        break;
      end
    end
    check("send_accept_timeout", int'(ok), 1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_word  = 8'h5A;
    in_dir   = ~dir;
  endtask

  task automatic drain();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk);
      if (q_exp.size() == 0) begin
        ok = 1'b1;
        break;
      end
    end
    #1;
    check("drain_timeout", int'(ok), 1);
  endtask

  // Monitor: every output beat is compared against the next queued expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (out_valid && out_ready) begin
        if (q_exp.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_beat: got index %0d, expected no beat", out_index);
        end else begin
          e = q_exp.pop_front();
          check("beat_index", int'(out_index), e.idx);
          check("beat_last", int'(out_last), e.last);
          check("beat_empty", int'(out_empty), e.empty);
          check("beat_in_ready", int'(in_ready), e.last);
        end
      end
    end
  end

  initial begin
    reset     = 1'b1;
    in_valid  = 1'b1;
    in_word   = 8'h55;
    in_dir    = 1'b0;
    out_ready = 1'b1;

    // Reset held two cycles with in_valid high
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check("reset_in_ready", int'(in_ready), 0);
      check("reset_out_valid", int'(out_valid), 0);
    end
    @(posedge clk);
    #1;
    reset    = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    check("post_reset_in_ready", int'(in_ready), 1);
    check("post_reset_out_valid", int'(out_valid), 0);
    @(posedge clk);
    #1;

    // Junior-first scan of 1001_0110
    push(1, 0, 0); push(2, 0, 0); push(4, 0, 0); push(7, 1, 0);
    send(8'b1001_0110, 1'b0);
    drain();

    // Senior-first scan of the same word
    push(7, 0, 0); push(4, 0, 0); push(2, 0, 0); push(1, 1, 0);
    send(8'b1001_0110, 1'b1);
    drain();

    // Zero word: single dummy beat, then idle
    push(0, 1, 1);
    send(8'b0000_0000, 1'b0);
    drain();
    @(negedge clk);
    check("zero_then_idle_valid", int'(out_valid), 0);
    check("zero_then_idle_ready", int'(in_ready), 1);
    @(posedge clk);
    #1;

    // Backpressure holds the first beat
    out_ready = 1'b0;
    push(0, 0, 0); push(1, 1, 0);
    send(8'b0000_0011, 1'b0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("bp_valid", int'(out_valid), 1);
      check("bp_index", int'(out_index), 0);
      check("bp_last", int'(out_last), 0);
      check("bp_in_ready", int'(in_ready), 0);
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    drain();

    // Back-to-back: second word accepted on the last beat of the first
    push(0, 0, 0); push(1, 1, 0); push(7, 1, 0);
    send(8'b0000_0011, 1'b0);
    send(8'b1000_0000, 1'b0);
    @(negedge clk);
    check("b2b_no_bubble_valid", int'(out_valid), 1);
    check("b2b_index", int'(out_index), 7);
    drain();

    // Abort: reset after two beats of 0xFF senior-first
    push(7, 0, 0); push(6, 0, 0);
    send(8'hFF, 1'b1);
    @(posedge clk);
    @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("abort_out_valid", int'(out_valid), 0);
    end
    check("abort_queue_consumed", q_exp.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
